// File: rtl/conv_pkg.sv
// Shared state encoding and elaboration helpers for the convolution address sequencer.
package conv_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int clog2_w(input int value);
        int w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    // Number of valid window positions along one axis; illegal geometry yields 1
    // so the dedicated parameter check reports it instead of a divide-by-zero.
    function automatic int out_dim(input int img, input int k, input int stride);
        if (stride < 1 || k < 1 || k > img) return 1;
        return (img - k) / stride + 1;
    endfunction

endpackage

// File: rtl/conv_win_counter.sv
// Row-major 2-D counter over a ROWS x COLS grid; wraps to (0,0) after the last cell.
module conv_win_counter
    import conv_pkg::*;
#(
    parameter int ROWS = 1,
    parameter int COLS = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_col_last,
    output logic o_last
);

    localparam int RW = clog2_w(ROWS);
    localparam int CW = clog2_w(COLS);

    logic [RW-1:0] row;
    logic [CW-1:0] col;

    assign o_col_last = (col == CW'(COLS - 1));
    assign o_last     = o_col_last && (row == RW'(ROWS - 1));

    // NOTE: sequential state is written only with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            row <= '0;
            col <= '0;
        end else if (i_inc) begin
            if (o_col_last) begin
                col <= '0;
                row <= o_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/conv_addr_sequencer.sv
// Walks every output window of a feature map, issuing per-tap read addresses, a MAC
// drain wait and a handshaked output write per window.
module conv_addr_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int K       = 3,
    parameter int STRIDE  = 1,
    parameter int ADDR_W  = 18,
    parameter int MAC_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_img_base,
    input  logic [ADDR_W-1:0] i_k_base,
    input  logic [ADDR_W-1:0] i_out_base,
    input  logic              i_out_ready,
    output logic [ADDR_W-1:0] o_img_addr,
    output logic [ADDR_W-1:0] o_k_addr,
    output logic              o_tap_valid,
    output logic              o_first_tap,
    output logic              o_last_tap,
    output logic [ADDR_W-1:0] o_out_addr,
    output logic              o_wr_en,
    output logic              o_busy,
    output logic              o_done
);

    localparam int OUT_W      = out_dim(IMG_W, K, STRIDE);
    localparam int OUT_H      = out_dim(IMG_H, K, STRIDE);
    localparam int KK         = K * K;
    localparam int DW         = clog2_w(MAC_LAT);
    localparam int DRAIN_LAST = (MAC_LAT > 0) ? MAC_LAT - 1 : 0;

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE * IMG_W);
    localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] IMG_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] K_SPAN   = ADDR_W'(KK - 1);

    if (K < 1 || STRIDE < 1 || K > IMG_W || K > IMG_H) begin : g_param_check
        $error("conv_addr_sequencer: K/STRIDE do not fit the image dimensions");
    end

    logic [2:0]        state;
    logic [DW-1:0]     drain_cnt;
    logic [ADDR_W-1:0] row_base;   // image address of window (orow, 0)
    logic [ADDR_W-1:0] win_base;   // image address of window (orow, ocol), tap (0,0)
    logic [ADDR_W-1:0] tap_row;    // image address of tap (kr, 0) in the current window
    logic [ADDR_W-1:0] k_base_r;
    logic [ADDR_W-1:0] k_last;
    logic [ADDR_W-1:0] out_ptr;
    logic [ADDR_W-1:0] next_win;

    logic start_ok, tap_col_last, tap_last, pos_col_last, pos_last, store_ok;

    assign start_ok = (state == S_IDLE) && i_start;
    assign store_ok = (state == S_STORE) && i_out_ready;
    assign next_win = pos_col_last ? row_base + ROW_STEP : win_base + COL_STEP;

    conv_win_counter #(.ROWS(K), .COLS(K)) u_tap_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (start_ok),
        .i_inc      (state == S_FETCH),
        .o_col_last (tap_col_last),
        .o_last     (tap_last)
    );

    conv_win_counter #(.ROWS(OUT_H), .COLS(OUT_W)) u_pos_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (start_ok),
        .i_inc      (store_ok),
        .o_col_last (pos_col_last),
        .o_last     (pos_last)
    );

    // Outputs are loaded on the edge that enters a state, so each strobe is a plain flop.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            drain_cnt   <= '0;
            row_base    <= '0;
            win_base    <= '0;
            tap_row     <= '0;
            k_base_r    <= '0;
            k_last      <= '0;
            out_ptr     <= '0;
            o_img_addr  <= '0;
            o_k_addr    <= '0;
            o_tap_valid <= 1'b0;
            o_first_tap <= 1'b0;
            o_last_tap  <= 1'b0;
            o_out_addr  <= '0;
            o_wr_en     <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state       <= S_FETCH;
                        row_base    <= i_img_base;
                        win_base    <= i_img_base;
                        tap_row     <= i_img_base;
                        k_base_r    <= i_k_base;
                        k_last      <= i_k_base + K_SPAN;
                        out_ptr     <= i_out_base;
                        o_busy      <= 1'b1;
                        o_tap_valid <= 1'b1;
                        o_first_tap <= 1'b1;
                        o_last_tap  <= (KK == 1);
                        o_img_addr  <= i_img_base;
                        o_k_addr    <= i_k_base;
                    end
                end
                S_FETCH: begin
                    o_first_tap <= 1'b0;
                    if (tap_last) begin
                        o_tap_valid <= 1'b0;
                        o_last_tap  <= 1'b0;
                        o_img_addr  <= '0;
                        o_k_addr    <= '0;
                        if (MAC_LAT == 0) begin
                            state      <= S_STORE;
                            o_wr_en    <= 1'b1;
                            o_out_addr <= out_ptr;
                        end else begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                        end
                    end else begin
                        o_k_addr   <= o_k_addr + ADDR_W'(1);
                        o_last_tap <= (o_k_addr + ADDR_W'(1)) == k_last;
                        if (tap_col_last) begin
                            tap_row    <= tap_row + IMG_STEP;
                            o_img_addr <= tap_row + IMG_STEP;
                        end else begin
                            o_img_addr <= o_img_addr + ADDR_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DW'(DRAIN_LAST)) begin
                        state      <= S_STORE;
                        o_wr_en    <= 1'b1;
                        o_out_addr <= out_ptr;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                S_STORE: begin
                    if (i_out_ready) begin
                        o_wr_en    <= 1'b0;
                        o_out_addr <= '0;
                        if (pos_last) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state       <= S_FETCH;
                            out_ptr     <= out_ptr + ADDR_W'(1);
                            if (pos_col_last) row_base <= row_base + ROW_STEP;
                            win_base    <= next_win;
                            tap_row     <= next_win;
                            o_tap_valid <= 1'b1;
                            o_first_tap <= 1'b1;
                            o_last_tap  <= (KK == 1);
                            o_img_addr  <= next_win;
                            o_k_addr    <= k_base_r;
                        end
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
